// File: rtl/enc_frame_sched.sv
// rtl/enc_frame_sched.sv - two-requester frame scheduler feeding an 8b/10b encoder word stream
// Wraps each granted frame in K28.5/K29.7 and emits K28.5 fillers while idle.
module enc_frame_sched #(
    parameter int MAX_FRAME   = 64,
    parameter int IDLE_PERIOD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid0,
    input  logic       valid1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic       ready0,
    output logic       ready1,
    input  logic       enc_ready,
    output logic       pushin,
    output logic       startin,
    output logic [8:0] datain,
    output logic [1:0] grant,
    output logic       trunc_err
);

    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam int IW = (IDLE_PERIOD > 1) ? $clog2(IDLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(MAX_FRAME - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_PERIOD - 1);
    localparam logic [8:0]    K28_5     = 9'h1BC;
    localparam logic [8:0]    K29_7     = 9'h1FD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_EOF,
        S_DROP
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          rr_q;
    logic [CW-1:0] byte_cnt_q;
    logic [IW-1:0] idle_cnt_q;
    logic          trunc_q;
    logic          pushin_q;
    logic          startin_q;
    logic [8:0]    datain_q;
    logic          trunc_err_q;

    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          in_frame;
    logic          take;
    logic          accept;
    logic          pick_d;
    logic [CW-1:0] byte_cnt_d;

    assign sel_valid  = owner_q ? valid1 : valid0;
    assign sel_data   = owner_q ? data1  : data0;
    assign sel_last   = owner_q ? last1  : last0;
    assign in_frame   = (state_q == S_SOF) || (state_q == S_DATA);
    // DROP drains the requester even while the encoder is stalled
    assign take       = (in_frame && enc_ready) || (state_q == S_DROP);
    assign accept     = take && sel_valid;
    assign pick_d     = (valid0 && valid1) ? rr_q : valid1;
    assign byte_cnt_d = byte_cnt_q + CW'(1);

    assign ready0    = take && !owner_q;
    assign ready1    = take && owner_q;
    assign grant     = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
    assign pushin    = pushin_q;
    assign startin   = startin_q;
    assign datain    = datain_q;
    assign trunc_err = trunc_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            trunc_q     <= 1'b0;
            pushin_q    <= 1'b0;
            startin_q   <= 1'b0;
            datain_q    <= 9'h000;
            trunc_err_q <= 1'b0;
        end else begin
            pushin_q    <= 1'b0;
            startin_q   <= 1'b0;
            trunc_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enc_ready) begin
                        if (valid0 || valid1) begin
                            owner_q    <= pick_d;
                            byte_cnt_q <= '0;
                            idle_cnt_q <= '0;
                            trunc_q    <= 1'b0;
                            pushin_q   <= 1'b1;
                            startin_q  <= 1'b1;
                            datain_q   <= K28_5;
                            state_q    <= S_SOF;
                        end else if (idle_cnt_q == IDLE_LAST) begin
                            idle_cnt_q <= '0;
                            pushin_q   <= 1'b1;
                            datain_q   <= K28_5;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end
                end
                S_SOF, S_DATA: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_d;
                        pushin_q   <= 1'b1;
                        datain_q   <= {1'b0, sel_data};
                        state_q    <= S_DATA;
                        // a last flag on the final permitted byte is a clean end
                        if (sel_last) begin
                            state_q <= S_EOF;
                        end else if (byte_cnt_q == LAST_CNT) begin
                            state_q <= S_EOF;
                            trunc_q <= 1'b1;
                        end
                    end
                end
                S_EOF: begin
                    if (enc_ready) begin
                        pushin_q    <= 1'b1;
                        datain_q    <= K29_7;
                        rr_q        <= !owner_q;
                        trunc_err_q <= trunc_q;
                        trunc_q     <= 1'b0;
                        state_q     <= trunc_q ? S_DROP : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (accept && sel_last) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
